tt_bist_harness: RTL and testbench
==================================

Name: tt_bist_harness

Overview:
Parametrised on-chip built-in self-test harness for tt_um_* user designs.
- Drives a pseudo-random stimulus stream (Galois LFSR) into a design's dedicated inputs.
- Compacts the design's responses into a multiple-input signature register (MISR), with a configurable response latency.
- Compares the final signature against a golden value and reports pass/fail.
- Replaces the fixed, externally driven stimulus harness with a self-contained, width- and length-generic engine that can also be used in silicon.

Parameters:
IN_W, 8, stimulus width (bits driven to the design under test)
OUT_W, 8, response width (bits sampled from the design under test)
SIG_W, 16, MISR/signature width; must be >= OUT_W
NUM_CYCLES, 256, stimulus vectors per run; range 1..2^16
RESP_LAT, 1, cycles from stimulus presentation to the corresponding response; range 1..8
LFSR_POLY, 8'h1D, Galois feedback taps for the stimulus LFSR (IN_W bits)
LFSR_SEED, 8'h01, LFSR load value at start; a zero seed loads 1 instead
MISR_POLY, 16'h1021, Galois feedback taps for the MISR (SIG_W bits)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin a run; honoured in IDLE and DONE only
abort  input  1  cancel a run; returns to IDLE on the next edge
golden_sig  input  SIG_W  expected signature; sampled when the run reaches DONE
stim_out  output  IN_W  stimulus vector, to the design's ui_in
stim_valid  output  1  high while stim_out carries a live vector
resp_in  input  OUT_W  response from the design's uo_out
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE
pass  output  1  registered (signature == golden_sig); meaningful only while done=1
signature  output  SIG_W  current MISR contents

Behaviour:
- Reset: all outputs are 0 after reset: stim_out, stim_valid, busy, done, pass, signature. State = IDLE, LFSR = 0, cycle counter = 0, valid-delay pipe = 0.
- A rst asserted mid-run has the same effect; abort, start and golden_sig are ignored while rst=1.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - stim_valid=0, stim_out=0.
  - start=1 -> load LFSR=seed, MISR=0, counter=0, pass=0; go to RUN.
- RUN:
  - stim_valid=1, stim_out=LFSR.
  - Each cycle: LFSR <= {L[IN_W-2:0],0} ^ (L[IN_W-1] ? LFSR_POLY : 0), and counter++.
  - Counter == NUM_CYCLES-1 -> DRAIN. So RUN lasts exactly NUM_CYCLES cycles; the first vector is the seed.
  - start in RUN is ignored.
- Valid-delay pipe:
  - RESP_LAT-deep shift register of stim_valid.
  - When the pipe tail is 1, MISR <= {S[SIG_W-2:0],0} ^ (S[SIG_W-1] ? MISR_POLY : 0) ^ zero-extend(resp_in).
  - Otherwise the MISR holds.
- DRAIN:
  - stim_valid=0, stim_out=0.
  - Lasts exactly RESP_LAT cycles, so the last response is captured; then go to DONE.
  - On DRAIN->DONE, pass <= (final MISR == golden_sig).
- DONE:
  - done=1; signature and pass are held.
  - start=1 -> new run, identical to start from IDLE.
- abort:
  - In RUN, DRAIN or DONE -> IDLE on the next edge.
  - Clears stim_valid, the delay pipe, done and pass.
  - signature keeps its last value until the next start.
  - start and abort in the same cycle: abort wins.
- Timing for NUM_CYCLES=N, RESP_LAT=L, start sampled at edge 0:
  - stim_valid high during cycles 1..N.
  - Captures occur at the ends of cycles 1+L..N+L.
  - done is first high in cycle N+L+1.
- Counter width is clog2(NUM_CYCLES+1). No wrap: the RUN exit compare precedes any overflow.
- LFSR and MISR free-run only in RUN/capture cycles; no other state changes them.

Decomposition:
- Package tt_bist_pkg holds:
  - state enum bist_state_t {IDLE, RUN, DRAIN, DONE}
  - function galois_step(value, poly, width) used by both registers
  - default polynomial constants
- One sub-module, tt_galois_reg (parameters WIDTH, POLY; inputs en, load, load_val, din), instantiated twice:
  - stimulus LFSR with din=0
  - MISR with din=resp_in

Test Plan:
1. IN_W=8, seed 01, LFSR_POLY 1D, N=10 -> stim_out sequence 01,02,04,08,10,20,40,80,1D,3A; stim_valid high for exactly 10 cycles.
2. SIG_W=8, MISR_POLY 1D, N=4, L=1, resp_in tied FF -> MISR steps FF,1C,C7,6C. signature=0x6C. done rises in cycle 6. With golden_sig=6C -> pass=1; with golden_sig=6D -> pass=0.
3. Loopback resp_in=stim_out delayed 1 cycle, SIG_W=8, N=4, L=1 -> captures 01,02,04,08; signature=0x00; matching golden 00 -> pass=1.
4. L=3, N=2 -> DRAIN lasts 3 cycles, exactly 2 captures, done first high in cycle 6.
5. Abort in cycle 3 of RUN, with start also asserted -> IDLE next cycle; stim_valid=0, done=0, pass=0. A later start restarts from seed 01.
6. rst asserted in DRAIN -> all outputs 0 on the next edge, state IDLE. Restart after deassert is bit-identical to the first run.

Source files
------------

// File: rtl/tt_bist_pkg.sv
// Shared types and helpers for the tt_um_* BIST harness.
// Holds the FSM state encoding, default polynomials and the Galois shift step.
package tt_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  localparam int unsigned GALOIS_MAX_W = 64;

  localparam logic [7:0]  DEF_LFSR_POLY = 8'h1D;
  localparam logic [7:0]  DEF_LFSR_SEED = 8'h01;
  localparam logic [15:0] DEF_MISR_POLY = 16'h1021;

  // One Galois step over the low `width` bits: shift left, fold the dropped MSB back through poly.
  function automatic logic [GALOIS_MAX_W-1:0] galois_step(
    input logic [GALOIS_MAX_W-1:0] value,
    input logic [GALOIS_MAX_W-1:0] poly,
    input int unsigned             width
  );
    logic [GALOIS_MAX_W-1:0] mask;
    logic [GALOIS_MAX_W-1:0] res;
    logic                    msb;
    mask = (width >= GALOIS_MAX_W) ? '1
                                   : ((GALOIS_MAX_W'(1) << width) - GALOIS_MAX_W'(1));
    msb  = (width == 0) ? 1'b0 : |((value >> (width - 1)) & GALOIS_MAX_W'(1));
    res  = (value << 1) & mask;
    if (msb) begin
      res = res ^ (poly & mask);
    end
    return res;
  endfunction

endpackage

// File: rtl/tt_galois_reg.sv
// Loadable Galois shift register with a parallel data input.
// Serves as the stimulus LFSR (din tied to zero) and as the response MISR.
module tt_galois_reg
  import tt_bist_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_LFSR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] step;

  always_comb begin
    step = WIDTH'(galois_step(GALOIS_MAX_W'(q), GALOIS_MAX_W'(POLY), WIDTH)) ^ din;
  end

  // Load takes priority over stepping so a restart always begins from load_val.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= step;
    end
  end

endmodule

// File: rtl/tt_bist_harness.sv
// Self-contained BIST engine: LFSR stimulus into a tt_um_* design, MISR response
// compaction with configurable latency, and a golden-signature pass/fail verdict.
module tt_bist_harness
  import tt_bist_pkg::*;
#(
  parameter int unsigned       IN_W       = 8,
  parameter int unsigned       OUT_W      = 8,
  parameter int unsigned       SIG_W      = 16,
  parameter int unsigned       NUM_CYCLES = 256,
  parameter int unsigned       RESP_LAT   = 1,
  parameter logic [IN_W-1:0]   LFSR_POLY  = IN_W'(DEF_LFSR_POLY),
  parameter logic [IN_W-1:0]   LFSR_SEED  = IN_W'(DEF_LFSR_SEED),
  parameter logic [SIG_W-1:0]  MISR_POLY  = SIG_W'(DEF_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] golden_sig,
  output logic [IN_W-1:0]  stim_out,
  output logic             stim_valid,
  input  logic [OUT_W-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned CNT_W   = $clog2(NUM_CYCLES + 1);
  localparam int unsigned DRAIN_W = 4;
  localparam logic [IN_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

  bist_state_t         state;
  bist_state_t         next_state;
  logic [CNT_W-1:0]    cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [RESP_LAT-1:0] vpipe;
  logic [IN_W-1:0]     lfsr_q;
  logic [SIG_W-1:0]    misr_q;

  logic                launch;
  logic                last_run;
  logic                last_drain;
  logic                capture;
  logic [IN_W-1:0]     lfsr_step;
  logic [SIG_W-1:0]    misr_d;

  logic [IN_W-1:0]     stim_out_d;
  logic                stim_valid_d;
  logic                busy_d;
  logic                done_d;
  logic                pass_d;

  always_comb begin
    launch     = start && !abort && ((state == IDLE) || (state == DONE));
    last_run   = (cnt == CNT_W'(NUM_CYCLES - 1));
    last_drain = (drain_cnt == DRAIN_W'(RESP_LAT - 1));
    capture    = vpipe[RESP_LAT-1] && !abort;
    lfsr_step  = IN_W'(galois_step(GALOIS_MAX_W'(lfsr_q), GALOIS_MAX_W'(LFSR_POLY), IN_W));
    misr_d     = capture
               ? (SIG_W'(galois_step(GALOIS_MAX_W'(misr_q), GALOIS_MAX_W'(MISR_POLY), SIG_W))
                  ^ SIG_W'(resp_in))
               : misr_q;
  end

  tt_galois_reg #(
    .WIDTH (IN_W),
    .POLY  (LFSR_POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       ((state == RUN) && !abort),
    .load     (launch),
    .load_val (SEED_EFF),
    .din      ('0),
    .q        (lfsr_q)
  );

  tt_galois_reg #(
    .WIDTH (SIG_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .en       (capture),
    .load     (launch),
    .load_val ('0),
    .din      (SIG_W'(resp_in)),
    .q        (misr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start)      next_state = RUN;
        RUN:     if (last_run)   next_state = DRAIN;
        DRAIN:   if (last_drain) next_state = DONE;
        DONE:    if (start)      next_state = RUN;
        default: next_state = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; the first vector of a run is the seed.
  always_comb begin
    stim_valid_d = (next_state == RUN);
    stim_out_d   = '0;
    busy_d       = (next_state == RUN) || (next_state == DRAIN);
    done_d       = (next_state == DONE);
    pass_d       = pass;
    if (next_state == RUN) begin
      stim_out_d = launch ? SEED_EFF : lfsr_step;
    end
    if (launch || abort) begin
      pass_d = 1'b0;
    end else if ((state == DRAIN) && last_drain) begin
      pass_d = (misr_d == golden_sig);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stim_out   <= '0;
      stim_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      stim_out   <= stim_out_d;
      stim_valid <= stim_valid_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      cnt <= '0;
    end else if ((state == RUN) && !abort) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state != DRAIN)) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  // Delays stim_valid by the response latency to mark MISR capture cycles.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      vpipe <= '0;
    end else begin
      vpipe <= RESP_LAT'({vpipe, stim_valid});
    end
  end

  assign signature = misr_q;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Self-checking bench for tt_bist_harness: two configurations run side by side,
// checked cycle by cycle against a behavioural model of the run timeline.
module tb_tt_bist_harness;

  localparam int NA = 4;
  localparam int LA = 1;
  localparam int NB = 10;
  localparam int LB = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  golden_a;
  logic [15:0] golden_b;
  logic [7:0]  resp_a;
  logic [7:0]  resp_b;

  logic [7:0]  stim_a;
  logic        stim_valid_a;
  logic        busy_a;
  logic        done_a;
  logic        pass_a;
  logic [7:0]  sig_a;

  logic [7:0]  stim_b;
  logic        stim_valid_b;
  logic        busy_b;
  logic        done_b;
  logic        pass_b;
  logic [15:0] sig_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_bist_harness #(
    .IN_W(8), .OUT_W(8), .SIG_W(8), .NUM_CYCLES(NA), .RESP_LAT(LA),
    .LFSR_POLY(8'h1D), .LFSR_SEED(8'h01), .MISR_POLY(8'h1D)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden_sig(golden_a),
    .stim_out(stim_a), .stim_valid(stim_valid_a), .resp_in(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
  );

  tt_bist_harness #(
    .IN_W(8), .OUT_W(8), .SIG_W(16), .NUM_CYCLES(NB), .RESP_LAT(LB),
    .LFSR_POLY(8'h1D), .LFSR_SEED(8'h00), .MISR_POLY(16'h1021)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden_sig(golden_b),
    .stim_out(stim_b), .stim_valid(stim_valid_b), .resp_in(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
  );

  // Multiply by x in GF(2)[x] modulo (x^w + poly), using integer arithmetic.
  function automatic int gf_mul2(input int v, input int poly, input int w);
    int r;
    r = v * 2;
    if (r >= (1 << w)) r = (r - (1 << w)) ^ poly;
    return r;
  endfunction

  // Stimulus vector presented in cycle c of a run of n vectors (0 outside the run).
  function automatic int stim_at(input int c, input int n);
    int v;
    if (c < 1 || c > n) return 0;
    v = 1;
    for (int k = 1; k < c; k++) v = gf_mul2(v, 'h1D, 8);
    return v;
  endfunction

  function automatic int resp_rand(input int unsigned rseed, input int c, input int which);
    int unsigned h;
    h = rseed ^ (32'(c) * 32'h9E3779B1) ^ (32'(which) * 32'h7F4A7C15);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    return int'(h >> 24);
  endfunction

  // Response mode: 0 pseudo-random, 1 constant FF, 2 stimulus looped back one cycle late.
  function automatic int resp_for(input int mode, input int c, input int n,
                                  input int unsigned rseed, input int which);
    if (mode == 1) return 'hFF;
    if (mode == 2) return stim_at(c - 1, n);
    return resp_rand(rseed, c, which);
  endfunction

  // Signature folds the responses of cycles 1+l .. n+l into a zeroed register.
  function automatic int expected_sig(input int n, input int l, input int w, input int poly,
                                      input int mode, input int unsigned rseed, input int which);
    int s;
    s = 0;
    for (int c = 1 + l; c <= n + l; c++) s = gf_mul2(s, poly, w) ^ resp_for(mode, c, n, rseed, which);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_and_check(input string tag, input int mode_a, input logic [7:0] gold_a,
                               input logic [15:0] gold_b, input int unsigned rseed);
    int exp_sa;
    int exp_sb;
    int drain_b;
    int tab[10];
    tab = '{'h01, 'h02, 'h04, 'h08, 'h10, 'h20, 'h40, 'h80, 'h1D, 'h3A};
    exp_sa  = expected_sig(NA, LA, 8, 'h1D, mode_a, rseed, 0);
    exp_sb  = expected_sig(NB, LB, 16, 'h1021, 0, rseed, 1);
    drain_b = 0;
    golden_a = gold_a;
    golden_b = gold_b;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (stim_valid_a !== 1'(c <= NA) || stim_a !== 8'(stim_at(c, NA)) ||
          busy_a !== 1'(c <= NA + LA) || done_a !== 1'(c > NA + LA)) begin
        errors++;
        $display("FAIL %s ctrl_a cyc %0d: got valid=%b stim=%h busy=%b done=%b, want valid=%b stim=%h busy=%b done=%b",
                 tag, c, stim_valid_a, stim_a, busy_a, done_a,
                 1'(c <= NA), 8'(stim_at(c, NA)), 1'(c <= NA + LA), 1'(c > NA + LA));
      end
      checks++;
      if (stim_valid_b !== 1'(c <= NB) || stim_b !== 8'(stim_at(c, NB)) ||
          busy_b !== 1'(c <= NB + LB) || done_b !== 1'(c > NB + LB)) begin
        errors++;
        $display("FAIL %s ctrl_b cyc %0d: got valid=%b stim=%h busy=%b done=%b, want valid=%b stim=%h busy=%b done=%b",
                 tag, c, stim_valid_b, stim_b, busy_b, done_b,
                 1'(c <= NB), 8'(stim_at(c, NB)), 1'(c <= NB + LB), 1'(c > NB + LB));
      end
      if (c <= NB) begin
        checks++;
        if (stim_b !== 8'(tab[c-1])) begin
          errors++;
          $display("FAIL %s stim_table cyc %0d: got %h want %h", tag, c, stim_b, 8'(tab[c-1]));
        end
      end
      if (busy_b && !stim_valid_b) drain_b++;
      resp_a = 8'(resp_for(mode_a, c, NA, rseed, 0));
      resp_b = 8'(resp_for(0, c, NB, rseed, 1));
      step();
    end
    checks++;
    if (drain_b != LB) begin
      errors++;
      $display("FAIL %s drain_len_b: got %0d want %0d", tag, drain_b, LB);
    end
    checks++;
    if (sig_a !== 8'(exp_sa) || pass_a !== 1'(exp_sa == int'(gold_a))) begin
      errors++;
      $display("FAIL %s sig_a: got sig=%h pass=%b want sig=%h pass=%b",
               tag, sig_a, pass_a, 8'(exp_sa), 1'(exp_sa == int'(gold_a)));
    end
    checks++;
    if (sig_b !== 16'(exp_sb) || pass_b !== 1'(exp_sb == int'(gold_b))) begin
      errors++;
      $display("FAIL %s sig_b: got sig=%h pass=%b want sig=%h pass=%b",
               tag, sig_b, pass_b, 16'(exp_sb), 1'(exp_sb == int'(gold_b)));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    golden_a = '0; golden_b = '0; resp_a = 8'hA5; resp_b = 8'h5A;
    repeat (3) step();
    checks++;
    if ({stim_a, stim_valid_a, busy_a, done_a, pass_a, sig_a} !== '0 ||
        {stim_b, stim_valid_b, busy_b, done_b, pass_b, sig_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h/%b%b%b%b/%h b=%h/%b%b%b%b/%h want all zero",
               stim_a, stim_valid_a, busy_a, done_a, pass_a, sig_a,
               stim_b, stim_valid_b, busy_b, done_b, pass_b, sig_b);
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) step();
    checks++;
    if (busy_a !== 1'b0 || stim_valid_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy_a=%b valid_b=%b done_b=%b want 0 0 0",
               busy_a, stim_valid_b, done_b);
    end
  endtask

  task automatic test_stimulus();
    run_and_check("stimulus", 0, 8'h00, 16'h0000, $urandom);
  endtask

  task automatic test_misr_pass();
    int unsigned rs;
    rs = $urandom;
    run_and_check("misr_pass", 1, 8'h6C, 16'(expected_sig(NB, LB, 16, 'h1021, 0, rs, 1)), rs);
    checks++;
    if (sig_a !== 8'h6C || pass_a !== 1'b1 || pass_b !== 1'b1) begin
      errors++;
      $display("FAIL misr_ff_golden: got sig_a=%h pass_a=%b pass_b=%b want 6c 1 1", sig_a, pass_a, pass_b);
    end
  endtask

  task automatic test_back_to_back();
    run_and_check("misr_fail", 1, 8'h6D, 16'h0000, $urandom);
    checks++;
    if (sig_a !== 8'h6C || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL misr_ff_mismatch: got sig_a=%h pass_a=%b want 6c 0", sig_a, pass_a);
    end
    run_and_check("b2b_random", 0, 8'($urandom), 16'($urandom), $urandom);
  endtask

  task automatic test_loopback();
    run_and_check("loopback", 2, 8'h00, 16'h0000, $urandom);
    checks++;
    if (sig_a !== 8'h00 || pass_a !== 1'b1) begin
      errors++;
      $display("FAIL loopback_sig: got sig_a=%h pass_a=%b want 00 1", sig_a, pass_a);
    end
  endtask

  task automatic test_abort();
    resp_a = 8'hFF;
    golden_a = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    checks++;
    if (stim_valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 ||
        stim_a !== 8'h00 || sig_a !== 8'hFF) begin
      errors++;
      $display("FAIL abort_a: got valid=%b busy=%b done=%b pass=%b stim=%h sig=%h want 0 0 0 0 00 ff",
               stim_valid_a, busy_a, done_a, pass_a, stim_a, sig_a);
    end
    checks++;
    if (stim_valid_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || pass_b !== 1'b0) begin
      errors++;
      $display("FAIL abort_b: got valid=%b busy=%b done=%b pass=%b want 0 0 0 0",
               stim_valid_b, busy_b, done_b, pass_b);
    end
    repeat (2) step();
    checks++;
    if (busy_a !== 1'b0 || sig_a !== 8'hFF) begin
      errors++;
      $display("FAIL abort_idle: got busy_a=%b sig_a=%h want 0 ff", busy_a, sig_a);
    end
    run_and_check("after_abort", 1, 8'h6C, 16'h0000, $urandom);
  endtask

  task automatic test_reset_mid_run();
    resp_a = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    step();
    checks++;
    if ({stim_a, stim_valid_a, busy_a, done_a, pass_a, sig_a} !== '0 ||
        {stim_b, stim_valid_b, busy_b, done_b, pass_b, sig_b} !== '0) begin
      errors++;
      $display("FAIL reset_in_drain: got a=%h/%b%b%b%b/%h b=%h/%b%b%b%b/%h want all zero",
               stim_a, stim_valid_a, busy_a, done_a, pass_a, sig_a,
               stim_b, stim_valid_b, busy_b, done_b, pass_b, sig_b);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    step();
    run_and_check("after_reset", 1, 8'h6C, 16'h0000, $urandom);
  endtask

  initial begin
    test_reset();
    test_stimulus();
    test_misr_pass();
    test_back_to_back();
    test_loopback();
    test_abort();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
